fifo_sync_ctrl: RTL

Parametrised successor to the team's basic synchronous FIFO. It adds a selectable first-word-fall-through (FWFT) mode, a fill count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It also adds a synchronous flush and accepts a write when full if a read happens in the same cycle. It sits between single-clock producer/consumer blocks (DMA, packet buffers) that need flow control with early warning.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 25 ++
 rtl/fifo_sync_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
// Mode encodings select the read-data path; ptr_width sizes pointers and count.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // One extra bit above the address width separates "full" from "empty".
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(FIFO_DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [$clog2(FIFO_DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]         rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // NOTE: storage has no reset; the pointers alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller with optional first-word-fall-through, fill count,
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cs,
  input  logic                                flush,
  input  logic                                clr_err,
  input  logic                                wr_en,
  input  logic                                rd_en,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [ptr_width(FIFO_DEPTH)-1:0]    count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int LOG = $clog2(FIFO_DEPTH);
  localparam int PW  = ptr_width(FIFO_DEPTH);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] DEPTH_C  = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic                  wr_req, rd_req;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  // Count is the modular pointer distance, so it survives any number of wraps.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign wr_req = cs & wr_en & ~flush;
  assign rd_req = cs & rd_en & ~flush;
  assign rd_ok  = rd_req & ~empty;
  assign wr_ok  = wr_req & (~full | rd_ok);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // A new error event outranks a clear issued in the same cycle.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_req & ~wr_ok) ovf_d = 1'b1;
    if (rd_req & empty)  unf_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[LOG-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[LOG-1:0]),
    .rdata_o (rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (flush) begin
        data_q <= '0;
      end else if (rd_ok) begin
        data_q <= rd_data;
      end
    end

    assign data_out = data_q;
  end

endmodule
